trigger_event_capture: RTL and testbench
========================================

// Module: trigger_event_capture
// PURPOSE
//  Host-side capture of FPGA event pulses: the reading end of the trigger-out path.
//  - Accepts one-cycle event pulses (e.g. counter-equals flags) on sys_clk.
//  - Keeps a sticky flag, a saturating count and a saturation flag per event.
//  - Host clears per-event state with trigger-in pulses.
//  - Host freezes all counts atomically with a snapshot trigger, then reads them over wire-outs.
// PARAMETERS
//  N_EV   2   number of event channels (1..16)
//  CNT_W  8   per-event counter width (1..15)
// PORTS
//  sys_clk     in   1       single clock; all logic is on its rising edge
//  reset       in   1       synchronous, active-high
//  ev_pulse    in   N_EV    one-cycle event pulses; bit i = channel i
//  clr_trig    in   N_EV    one-cycle clear pulses from the trigger-in endpoint
//  snap_trig   in   1       one-cycle snapshot pulse from the trigger-in endpoint
//  sel         in   4       wire-in; selects the channel shown on count_word
//  sticky      out  16      {zero-ext, sticky[N_EV-1:0]}; drives a wire-out
//  count_word  out  16      {sat_shad[sel], zeros, shad[sel]}; drives a wire-out
//  new_event   out  1       one-cycle pulse; feeds the trigger-out endpoint
// BEHAVIOUR
//  Reset
//  - At reset, all sticky, cnt, sat, shad, sat_shad, count_word and new_event go to 0.
//  - reset overrides every other input.
//  Event i (ev_pulse[i]=1, clr_trig[i]=0)
//  - At the next edge: sticky[i]<=1.
//  - cnt[i]<=cnt[i]+1 when cnt[i] < 2^CNT_W-1.
//  - Otherwise cnt[i] holds and sat[i]<=1. Counters never wrap.
//  Clear i (clr_trig[i]=1)
//  - sticky[i], cnt[i] and sat[i] go to 0.
//  - The shadow registers are not affected.
//  Clear and event on the same cycle
//  - The clear applies first, then the event.
//  - Result: sticky[i]=1, cnt[i]=1, sat[i]=0.
//  Snapshot
//  - On snap_trig=1, every channel copies shad[i]<=cnt[i] and sat_shad[i]<=sat[i].
//  - The copy uses pre-edge values, so an event on that same cycle is counted in cnt only.
//  - A clear on the same cycle does not change the values captured.
//  Readout
//  - count_word is registered from shad[sel]/sat_shad[sel]. Result: bit15 = sat flag, low CNT_W bits = count.
//  - When sel >= N_EV, count_word is 0.
//  - Latency: a snap_trig edge at cycle t gives the new value on count_word after edge t+1.
//  - A sel change appears after 1 edge.
//  - sticky output is combinational from the sticky register (0 latency after its update edge).
//  new_event
//  - High for exactly 1 cycle, on the edge after any sticky bit goes 0->1.
//  - Each new set bit produces one pulse; simultaneous sets in one cycle produce a single pulse.
//  - An event on a channel that is already sticky produces no pulse.
//  - A clear that races a new set still lets the set pulse through.
//  Reset mid-operation
//  - Reset zeroes everything on that edge.
//  - Events presented in the same cycle are lost.
// STRUCTURE
//  Package tec_pkg
//  - Constants: MAX_EV=16, WORD_W=16, SAT_BIT=15.
//  - Function: sat_inc(cnt, max).
//  Sub-module tec_channel, one instance per event (generate loop)
//  - Holds sticky, cnt, sat, shad and sat_shad.
//  - Outputs sticky_rise.
//  Top-level logic
//  - sel mux, count_word register, OR-reduce of sticky_rise into the new_event register.
// TESTING
//  1. Reset, then 3 pulses on ev_pulse[0], snap_trig, sel=0 -> count_word=0x0003, sticky=0x0001, one new_event pulse only.
//  2. 260 pulses on ch1, snap, sel=1 -> count_word=0x80FF; cnt stays at 0xFF, no wrap.
//  3. clr_trig[0] and ev_pulse[0] on the same cycle after cnt=5 -> cnt=1, sticky[0]=1, sat=0; new_event pulses only if sticky was 0 before.
//  4. snap_trig and ev_pulse[1] on the same cycle with cnt=4 -> count_word=0x0004; next snap -> 0x0005.
//  5. sel=7 with N_EV=2 -> count_word=0x0000; sel back to 0 -> shad[0] after 1 edge.
//  6. reset asserted mid-stream with counts nonzero -> all outputs 0 on the next edge; an ev_pulse during reset is not counted.

Source files
------------

// File: rtl/tec_pkg.sv
// Shared constants and helpers for the trigger event capture block.
package tec_pkg;

    localparam int MAX_EV  = 16;  // widest channel count the wire-outs can show
    localparam int WORD_W  = 16;  // wire-out word width
    localparam int SAT_BIT = 15;  // position of the saturation flag in count_word

    // Increment that stops at max instead of wrapping.
    function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] cnt,
                                                   input logic [WORD_W-1:0] max);
        if (cnt < max) begin
            return cnt + 16'd1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/tec_channel.sv
// One event channel: sticky flag, saturating count, saturation flag and the
// snapshot shadow copies. sticky_rise is high for the cycle after sticky
// goes 0->1. It comes from a delayed copy of sticky, so a clear that lands
// right after the set cannot swallow the pulse.
module tec_channel
    import tec_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             ev,
    input  logic             clr,
    input  logic             snap,
    output logic             sticky,
    output logic [CNT_W-1:0] shad,
    output logic             sat_shad,
    output logic             sticky_rise
);

    logic [CNT_W-1:0]  cnt;
    logic              sat;
    logic              sticky_d;
    logic [WORD_W-1:0] cnt_ext;
    logic [WORD_W-1:0] max_ext;
    logic [WORD_W-1:0] cnt_nxt;

    assign cnt_ext = {{(WORD_W-CNT_W){1'b0}}, cnt};
    assign max_ext = {{(WORD_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};
    assign cnt_nxt = sat_inc(cnt_ext, max_ext);

    // Channel state: clear first then event; snapshot copies pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            sticky   <= 1'b0;
            sticky_d <= 1'b0;
            cnt      <= '0;
            sat      <= 1'b0;
            shad     <= '0;
            sat_shad <= 1'b0;
        end else begin
            sticky_d <= sticky;
            if (snap) begin
                shad     <= cnt;
                sat_shad <= sat;
            end
            if (clr) begin
                // A clear with a coincident event leaves count 1, sticky set.
                sticky <= ev;
                cnt    <= '0;
                cnt[0] <= ev;
                sat    <= 1'b0;
            end else if (ev) begin
                sticky <= 1'b1;
                cnt    <= cnt_nxt[CNT_W-1:0];
                if (cnt_nxt == cnt_ext) begin
                    sat <= 1'b1;
                end
            end
        end
    end

    assign sticky_rise = sticky & ~sticky_d;

endmodule

// File: rtl/trigger_event_capture.sv
// Host-side capture of event pulses: per-channel sticky/count/saturation,
// atomic snapshot of all counts, a registered readout word selected by sel,
// and a one-cycle new_event pulse whenever any sticky bit newly sets.
module trigger_event_capture
    import tec_pkg::*;
#(
    parameter int N_EV  = 2,
    parameter int CNT_W = 8
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic [N_EV-1:0]   ev_pulse,
    input  logic [N_EV-1:0]   clr_trig,
    input  logic              snap_trig,
    input  logic [3:0]        sel,
    output logic [WORD_W-1:0] sticky,
    output logic [WORD_W-1:0] count_word,
    output logic              new_event
);

    // Arrays are sized to MAX_EV so sel indexes them exactly; unused
    // channels read as zero.
    logic [CNT_W-1:0]  shad_a [MAX_EV];
    logic [MAX_EV-1:0] sat_shad_v;
    logic [MAX_EV-1:0] sticky_v;
    logic [MAX_EV-1:0] rise_v;
    logic [WORD_W-1:0] word_d;

    for (genvar i = 0; i < MAX_EV; i++) begin : g_ch
        if (i < N_EV) begin : g_used
            tec_channel #(
                .CNT_W(CNT_W)
            ) u_ch (
                .sys_clk    (sys_clk),
                .reset      (reset),
                .ev         (ev_pulse[i]),
                .clr        (clr_trig[i]),
                .snap       (snap_trig),
                .sticky     (sticky_v[i]),
                .shad       (shad_a[i]),
                .sat_shad   (sat_shad_v[i]),
                .sticky_rise(rise_v[i])
            );
        end else begin : g_unused
            assign sticky_v[i]   = 1'b0;
            assign shad_a[i]     = '0;
            assign sat_shad_v[i] = 1'b0;
            assign rise_v[i]     = 1'b0;
        end
    end

    assign sticky = sticky_v;

    // Readout mux: sat flag in bit 15, count in the low bits, 0 for absent channels.
    always_comb begin
        word_d = '0;
        if (int'(sel) < N_EV) begin
            word_d[CNT_W-1:0] = shad_a[sel];
            word_d[SAT_BIT]   = sat_shad_v[sel];
        end
    end

    // Register the readout word and merge all channel rises into one pulse.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            count_word <= '0;
            new_event  <= 1'b0;
        end else begin
            count_word <= word_d;
            new_event  <= |rise_v;
        end
    end

endmodule

// File: tb/tb_trigger_event_capture.sv
// Directed bench for trigger_event_capture. Expected readout words are
// queued when a snapshot is issued and compared when the word is read.
module tb_trigger_event_capture;

    localparam int N_EV  = 2;
    localparam int CNT_W = 8;

    logic            sys_clk = 1'b0;
    logic            reset;
    logic [N_EV-1:0] ev_pulse;
    logic [N_EV-1:0] clr_trig;
    logic            snap_trig;
    logic [3:0]      sel;
    logic [15:0]     sticky;
    logic [15:0]     count_word;
    logic            new_event;

    logic [15:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int ne_cnt = 0;

    trigger_event_capture #(
        .N_EV (N_EV),
        .CNT_W(CNT_W)
    ) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .ev_pulse  (ev_pulse),
        .clr_trig  (clr_trig),
        .snap_trig (snap_trig),
        .sel       (sel),
        .sticky    (sticky),
        .count_word(count_word),
        .new_event (new_event)
    );

    // Clock generation.
    always #5 sys_clk = ~sys_clk;

    // Count new_event pulses, sampled mid-cycle.
    always @(negedge sys_clk) begin
        if (new_event) ne_cnt++;
    end

    // One clock edge, then settle; inputs change and outputs are sampled here.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    task automatic pulse_ev(input logic [N_EV-1:0] mask, input int n);
        ev_pulse = mask;
        tick(n);
        ev_pulse = '0;
    endtask

    task automatic pulse_clr(input logic [N_EV-1:0] mask);
        clr_trig = mask;
        tick();
        clr_trig = '0;
    endtask

    // Snapshot, select a channel and compare the word two edges later.
    task automatic snap_read(input string tag, input logic [3:0] s, input logic [15:0] e);
        sel       = s;
        snap_trig = 1'b1;
        exp_q.push_back(e);
        tick();
        snap_trig = 1'b0;
        tick();
        if (exp_q.size() == 0) begin
            check({tag, "_q_empty"}, 16'hdead, 16'h0000);
        end else begin
            check(tag, count_word, exp_q.pop_front());
        end
    endtask

    initial begin
        reset     = 1'b1;
        ev_pulse  = '0;
        clr_trig  = '0;
        snap_trig = 1'b0;
        sel       = 4'd0;
        tick(2);
        check("rst_sticky", sticky, 16'h0000);
        check("rst_count_word", count_word, 16'h0000);
        check("rst_new_event", {15'd0, new_event}, 16'h0000);
        reset = 1'b0;
        tick();

        // 1: three events on channel 0.
        pulse_ev(2'b01, 3);
        sel       = 4'd0;
        snap_trig = 1'b1;
        exp_q.push_back(16'h0003);
        tick();
        snap_trig = 1'b0;
        check("t1_latency_old", count_word, 16'h0000);
        tick();
        check("t1_count_word", count_word, exp_q.pop_front());
        check("t1_sticky", sticky, 16'h0001);
        tick(2);
        check("t1_ne_cnt", 16'(ne_cnt), 16'd1);

        // 2: 260 events on channel 1 saturate at 0xFF.
        pulse_ev(2'b10, 260);
        snap_read("t2_sat_word", 4'd1, 16'h80FF);
        check("t2_ne_cnt", 16'(ne_cnt), 16'd2);
        check("t2_sticky", sticky, 16'h0003);

        // 3: clear leaves shadows untouched; clear+event gives count 1.
        pulse_clr(2'b01);
        check("t3_sticky_clr", sticky, 16'h0002);
        sel = 4'd0;
        tick();
        check("t3_shad_kept", count_word, 16'h0003);
        pulse_ev(2'b01, 5);
        tick(2);
        check("t3_ne_after_set", 16'(ne_cnt), 16'd3);
        ev_pulse = 2'b01;
        clr_trig = 2'b01;
        tick();
        ev_pulse = '0;
        clr_trig = '0;
        tick(2);
        check("t3_ne_no_pulse", 16'(ne_cnt), 16'd3);
        snap_read("t3_clr_ev_word", 4'd0, 16'h0001);
        check("t3_sticky_set", sticky, 16'h0003);
        pulse_clr(2'b01);
        ev_pulse = 2'b01;
        clr_trig = 2'b01;
        tick();
        ev_pulse = '0;
        clr_trig = '0;
        tick(2);
        check("t3_ne_pulse", 16'(ne_cnt), 16'd4);

        // 4: snapshot and event on the same cycle.
        pulse_clr(2'b10);
        pulse_ev(2'b10, 4);
        sel       = 4'd1;
        snap_trig = 1'b1;
        ev_pulse  = 2'b10;
        exp_q.push_back(16'h0004);
        tick();
        snap_trig = 1'b0;
        ev_pulse  = '0;
        tick();
        check("t4_snap_pre", count_word, exp_q.pop_front());
        snap_read("t4_snap_next", 4'd1, 16'h0005);
        check("t4_ne_cnt", 16'(ne_cnt), 16'd5);
        // Clear racing a fresh set still pulses.
        pulse_clr(2'b10);
        pulse_ev(2'b10, 1);
        pulse_clr(2'b10);
        tick(2);
        check("t4_race_ne", 16'(ne_cnt), 16'd6);
        check("t4_race_sticky", sticky, 16'h0001);

        // 5: out-of-range select.
        sel = 4'd7;
        tick();
        check("t5_sel7", count_word, 16'h0000);
        sel = 4'd0;
        tick();
        check("t5_sel0", count_word, 16'h0001);

        // 6: reset mid-stream, with an event during reset.
        pulse_ev(2'b11, 2);
        reset    = 1'b1;
        ev_pulse = 2'b01;
        tick();
        check("t6_sticky", sticky, 16'h0000);
        check("t6_count_word", count_word, 16'h0000);
        check("t6_new_event", {15'd0, new_event}, 16'h0000);
        reset    = 1'b0;
        ev_pulse = '0;
        tick();
        snap_read("t6_after_rst", 4'd0, 16'h0000);
        snap_read("t6_after_rst1", 4'd1, 16'h0000);
        check("t6_sticky_after", sticky, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
